// File: rtl/aes_stream_ctrl.sv
// Valid/ready stream front end for a fixed-latency, non-stallable AES128 pipeline.
// A block is admitted only when its result already owns a slot in the output FIFO.
module aes_stream_ctrl #(
    parameter int LATENCY    = 11,
    parameter int FIFO_DEPTH = 16,
    parameter int TAG_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [127:0]       s_plain,
    input  logic [127:0]       s_key,
    input  logic [TAG_W-1:0]   s_tag,
    output logic [127:0]       core_plain,
    output logic [127:0]       core_key,
    input  logic [127:0]       core_cipher,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [127:0]       m_cipher,
    output logic [TAG_W-1:0]   m_tag,
    output logic               busy,
    output logic [31:0]        blk_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic               accept;
    logic               push;
    logic               pop;
    logic [LATENCY-1:0] vld;
    logic [TAG_W-1:0]   tag_pipe [LATENCY];
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_cnt;
    logic [CW:0]        occupancy;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [127:0]       cipher_mem [FIFO_DEPTH];
    logic [TAG_W-1:0]   tag_mem [FIFO_DEPTH];

    // Credit is taken at accept and returned only at pop, never early.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign s_ready   = occupancy < DEPTH_OCC;
    assign accept    = s_valid & s_ready;
    assign push      = vld[LATENCY-1];
    assign m_valid   = fifo_cnt != '0;
    assign pop       = m_valid & m_ready;
    assign busy      = occupancy != '0;

    assign core_plain = s_plain;
    assign core_key   = s_key;
    assign m_cipher   = cipher_mem[rd_ptr];
    assign m_tag      = tag_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            vld         <= {vld[LATENCY-2:0], accept};
            tag_pipe[0] <= s_tag;
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight  <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            blk_count <= '0;
        end else begin
            if (accept && !push) begin
                inflight <= inflight + 1'b1;
            end else if (!accept && push) begin
                inflight <= inflight - 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                blk_count <= blk_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cipher_mem[wr_ptr] <= core_cipher;
            tag_mem[wr_ptr]    <= tag_pipe[LATENCY-1];
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !(push && fifo_cnt == DEPTH_CNT)
    ) else $error("aes_stream_ctrl: push into full FIFO");

endmodule
